// File: rtl/bam_pkg.sv
// bam_pkg: pipeline mode constants and a golden bit-cell model shared by the multiplier cell and its benches.
package bam_pkg;
  localparam int PIPE_COMB = 0;
  localparam int PIPE_REG  = 1;
  function automatic logic [1:0] bam_ref(input logic a, input logic b, input logic p, input logic c);
    return {1'b0, a & b} + {1'b0, p} + {1'b0, c};
  endfunction
endpackage

// File: rtl/bam_fa.sv
// bam_fa: partial-product AND feeding a full adder with the incoming sum and carry bits.
module bam_fa (
  input  logic A,
  input  logic B,
  input  logic pre_OUT,
  input  logic Carry,
  output logic OUT,
  output logic Carry_out
);
  logic pp;
  assign pp        = A & B;
  assign OUT       = pp ^ pre_OUT ^ Carry;
  assign Carry_out = (pp & pre_OUT) | (pp & Carry) | (pre_OUT & Carry);
endmodule

// File: rtl/bam_cell.sv
// bam_cell: N independent Baugh-Wooley multiplier bit cells with an optional async-reset output register.
module bam_cell
  import bam_pkg::*;
#(
  parameter int N    = 1,
  parameter int PIPE = PIPE_COMB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] pre_OUT,
  input  logic [N-1:0] Carry,
  output logic [N-1:0] OUT,
  output logic [N-1:0] Carry_out
);
  logic [N-1:0] sum, cout, sum_q, cout_q;
  for (genvar i = 0; i < N; i++) begin : g_lane
    bam_fa u_fa (
      .A(A[i]), .B(B[i]), .pre_OUT(pre_OUT[i]), .Carry(Carry[i]),
      .OUT(sum[i]), .Carry_out(cout[i])
    );
  end
  // The register bank exists in both modes; the combinational build simply never selects it.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sum_q  <= '0;
      cout_q <= '0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  assign OUT       = (PIPE == PIPE_REG) ? sum_q : sum;
  assign Carry_out = (PIPE == PIPE_REG) ? cout_q : cout;
endmodule

// File: tb/tb_bam_cell.sv
// tb_bam_cell: directed and random checks of combinational and registered bit-cell builds.
module tb_bam_cell;
  logic clk = 1'b0, rst = 1'b1;
  logic a1, b1, p1, c1, o1, co1;
  logic [3:0] a4, b4, p4, c4, o4, co4;
  logic [3:0] ap, bp, pp, cp, op, cop;
  logic [3:0] eo, eco, ho, hco;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  bam_cell #(.N(1), .PIPE(0)) u1 (.clk(clk), .rst(rst), .A(a1), .B(b1), .pre_OUT(p1), .Carry(c1), .OUT(o1), .Carry_out(co1));
  bam_cell #(.N(4), .PIPE(0)) u4 (.clk(clk), .rst(rst), .A(a4), .B(b4), .pre_OUT(p4), .Carry(c4), .OUT(o4), .Carry_out(co4));
  bam_cell #(.N(4), .PIPE(1)) up (.clk(clk), .rst(rst), .A(ap), .B(bp), .pre_OUT(pp), .Carry(cp), .OUT(op), .Carry_out(cop));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: each lane counts how many of (a AND b), p, c are set.
  task automatic model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] p, input logic [3:0] c,
                       output logic [3:0] o, output logic [3:0] co);
    for (int i = 0; i < 4; i++) begin
      int s;
      s = ((a[i] && b[i]) ? 1 : 0) + (p[i] ? 1 : 0) + (c[i] ? 1 : 0);
      o[i]  = (s % 2) == 1;
      co[i] = s >= 2;
    end
  endtask

  initial begin
    {a1, b1, p1, c1} = '0;
    {a4, b4, p4, c4} = '0;
    {ap, bp, pp, cp} = '0;
    #1;
    chk("reset_out", {4'h0, op}, 8'h00);
    chk("reset_cout", {4'h0, cop}, 8'h00);
    for (int i = 0; i < 16; i++) begin
      a1 = i[3]; b1 = i[2]; p1 = i[1]; c1 = i[0];
      #1;
      model({3'b0, a1}, {3'b0, b1}, {3'b0, p1}, {3'b0, c1}, eo, eco);
      chk($sformatf("tt%0d_out", i), {7'h0, o1}, {7'h0, eo[0]});
      chk($sformatf("tt%0d_cout", i), {7'h0, co1}, {7'h0, eco[0]});
    end
    a1 = 1; b1 = 1; p1 = 1; c1 = 1; #1;
    chk("tt_all1", {6'h0, co1, o1}, 8'h03);
    a1 = 1; b1 = 0; p1 = 1; c1 = 1; #1;
    chk("tt_b0", {6'h0, co1, o1}, 8'h02);
    a1 = 0; b1 = 1; p1 = 0; c1 = 0; #1;
    chk("tt_zero", {6'h0, co1, o1}, 8'h00);
    a1 = 0; b1 = 1; p1 = 1; c1 = 0; #1;
    chk("and_gate", {6'h0, co1, o1}, 8'h01);
    a4 = 4'b1111; b4 = 4'b1010; p4 = 4'b0110; c4 = 4'b0011; #1;
    chk("lanes_out", {4'h0, o4}, 8'h0f);
    chk("lanes_cout", {4'h0, co4}, 8'h02);
    for (int i = 0; i < 40; i++) begin
      {a4, b4, p4, c4} = 16'($urandom);
      #1;
      model(a4, b4, p4, c4, eo, eco);
      chk($sformatf("rnd%0d", i), {co4, o4}, {eco, eo});
    end
    @(negedge clk);
    chk("rst_hold_out", {4'h0, op}, 8'h00);
    rst = 0;
    ho = '0; hco = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      {ap, bp, pp, cp} = 16'($urandom);
      #1;
      chk($sformatf("pipe_hold%0d", i), {cop, op}, {hco, ho});
      model(ap, bp, pp, cp, ho, hco);
      @(posedge clk); #1;
      chk($sformatf("pipe%0d", i), {cop, op}, {hco, ho});
    end
    @(negedge clk);
    ap = 4'hf; bp = 4'hf; pp = 4'hf; cp = 4'h0; #1;
    chk("lat_before", {cop, op}, {hco, ho});
    @(posedge clk); #1;
    chk("lat_after", {cop, op}, 8'hf0);
    @(negedge clk);
    cp = 4'hf;
    @(posedge clk); #1;
    chk("ones_loaded", {cop, op}, 8'hff);
    #2 rst = 1; #1;
    chk("async_rst", {cop, op}, 8'h00);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_through_edge", {cop, op}, 8'h00);
    end
    @(negedge clk);
    ap = 4'b1100; bp = 4'b1010; pp = 4'b0101; cp = 4'b0011;
    rst = 0; #1;
    chk("rel_before_edge", {cop, op}, 8'h00);
    model(ap, bp, pp, cp, eo, eco);
    @(posedge clk); #1;
    chk("rel_first_edge", {cop, op}, {eco, eo});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
